// File: rtl/lsu_queued.sv
// lsu_queued: load/store unit. Local DMEM accesses issue in the same cycle.
// Remote accesses go through a small request FIFO, gated by an
// outstanding-request credit limit. A fence FSM holds every op until all
// remote traffic has retired.
module lsu_queued #(
    parameter int data_width_p  = 32,
    parameter int dmem_size_p   = 1024,
    parameter int queue_depth_p = 4,
    parameter int max_out_p     = 16,
    localparam int mask_w_lp    = data_width_p / 8,
    localparam int dmem_aw_lp   = $clog2(dmem_size_p),
    localparam int cnt_w_lp     = $clog2(max_out_p + 1),
    localparam int req_w_lp     = 2 * data_width_p + mask_w_lp + 11
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic                    ld_i,
    input  logic                    st_i,
    input  logic                    amo_i,
    input  logic [1:0]              size_i,
    input  logic [data_width_p-1:0] rs1_i,
    input  logic [data_width_p-1:0] rs2_i,
    input  logic [data_width_p-1:0] offset_i,
    input  logic [4:0]              rd_i,
    input  logic [5:0]              tg_x_cord_i,
    input  logic [4:0]              tg_y_cord_i,
    input  logic                    fence_i,
    output logic                    stall_o,
    output logic                    dmem_v_o,
    output logic                    dmem_w_o,
    output logic [dmem_aw_lp-1:0]   dmem_addr_o,
    output logic [data_width_p-1:0] dmem_data_o,
    output logic [mask_w_lp-1:0]    dmem_mask_o,
    output logic                    remote_v_o,
    input  logic                    remote_ready_i,
    output logic [req_w_lp-1:0]     remote_req_o,
    input  logic                    resp_v_i,
    output logic [cnt_w_lp-1:0]     out_cnt_o,
    output logic                    misalign_o
);
    localparam int ptr_w_lp  = $clog2(queue_depth_p);
    localparam int fcnt_w_lp = $clog2(queue_depth_p + 1);
    localparam logic [data_width_p-1:0] local_lim_lp = data_width_p'(4 * dmem_size_p);

    typedef enum logic {IDLE, DRAIN} state_e;

    // Byte-enable mask: bytes one-hot on the byte lane, halves on the half lane.
    function automatic logic [mask_w_lp-1:0] form_mask(input logic [1:0] size,
                                                       input logic [1:0] bsel);
        logic [mask_w_lp-1:0] m;
        case (size)
            2'd0:    m = mask_w_lp'(1) << bsel;
            2'd1:    m = mask_w_lp'(3) << {bsel[1], 1'b0};
            default: m = '1;
        endcase
        return m;
    endfunction

    // Sub-word store data is replicated across every lane so the mask picks it.
    function automatic logic [data_width_p-1:0] replicate_data(input logic [1:0] size,
                                                               input logic [data_width_p-1:0] d);
        logic [data_width_p-1:0] r;
        case (size)
            2'd0:    r = {mask_w_lp{d[7:0]}};
            2'd1:    r = {(mask_w_lp / 2){d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(queue_depth_p - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [data_width_p-1:0] addr;
    logic                    misaligned;
    logic                    tg_local;
    logic                    is_local;
    logic                    remote_cand;
    logic [mask_w_lp-1:0]    mask;
    logic [data_width_p-1:0] store_data;

    logic [req_w_lp-1:0]     fifo_mem [queue_depth_p];
    logic [ptr_w_lp-1:0]     rd_ptr;
    logic [ptr_w_lp-1:0]     wr_ptr;
    logic [fcnt_w_lp-1:0]    fifo_cnt;
    logic [cnt_w_lp-1:0]     out_cnt;
    state_e                  state;

    logic                    mem_op;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    deq;
    logic                    enq;
    logic                    resp_dec;
    logic [31:0]             pending;
    logic                    credit_block;
    logic                    drained;
    logic                    drain_busy;
    logic                    accept;

    // Tile-group address: {3'b001, 2'bx, y[4:0], x[5:0], offset[15:0]}.
    assign addr        = rs1_i + offset_i;
    assign misaligned  = ((size_i == 2'd1) & addr[0]) | ((size_i[1]) & (addr[1:0] != 2'b00));
    assign tg_local    = (addr[31:29] == 3'b001) & (addr[21:16] == tg_x_cord_i)
                       & (addr[26:22] == tg_y_cord_i)
                       & ({{(data_width_p-16){1'b0}}, addr[15:0]} < local_lim_lp);
    assign is_local    = ~amo_i & ((addr < local_lim_lp) | tg_local);
    assign remote_cand = ~misaligned & ~is_local;
    assign mask        = form_mask(size_i, addr[1:0]);
    assign store_data  = replicate_data(size_i, rs2_i);

    assign mem_op       = v_i & ~reset_i;
    assign fifo_empty   = (fifo_cnt == '0);
    assign fifo_full    = (fifo_cnt == fcnt_w_lp'(queue_depth_p));
    assign remote_v_o   = ~fifo_empty & ~reset_i;
    assign deq          = remote_v_o & remote_ready_i;
    assign resp_dec     = resp_v_i & (out_cnt != '0);
    assign pending      = 32'(out_cnt) + 32'(fifo_cnt);
    assign credit_block = pending >= 32'(max_out_p);

    // A response landing this cycle on the last credit counts as drained,
    // so the fence releases in the same cycle the response arrives.
    assign drained    = fifo_empty & ((out_cnt == '0) | ((out_cnt == cnt_w_lp'(1)) & resp_v_i));
    assign drain_busy = (state == DRAIN) & ~drained;

    assign stall_o    = mem_op & (drain_busy |
                        (remote_cand & ((fifo_full & ~deq) | credit_block)));
    assign accept     = mem_op & ~stall_o;
    assign enq        = accept & remote_cand;
    assign misalign_o = accept & misaligned;

    assign dmem_v_o    = accept & is_local & ~misaligned;
    assign dmem_w_o    = st_i;
    assign dmem_addr_o = addr[dmem_aw_lp+1:2];
    assign dmem_data_o = store_data;
    assign dmem_mask_o = mask;

    assign remote_req_o = fifo_mem[rd_ptr];
    assign out_cnt_o    = out_cnt;

    // Request storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= {st_i, amo_i, mask, rd_i, size_i, addr[1:0], store_data, addr};
        end
    end

    // FIFO pointers and occupancy; a full FIFO dequeuing accepts in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_next(wr_ptr);
            if (deq) rd_ptr <= ptr_next(rd_ptr);
            if (enq & ~deq)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (deq & ~enq) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Outstanding counter: dequeue adds a credit in use, a response frees one.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_cnt <= '0;
        end else if (deq & ~resp_dec) begin
            out_cnt <= out_cnt + 1'b1;
        end else if (resp_dec & ~deq) begin
            out_cnt <= out_cnt - 1'b1;
        end
    end

    // Fence FSM: enter DRAIN on fence, leave once queue and credits are clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (fence_i) state <= DRAIN;
                DRAIN:   if (drained) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_queued.sv
// tb_lsu_queued: directed scenarios plus randomized traffic for lsu_queued,
// checked against a queue-based behavioural model of the default-parameter
// instance; a second instance with max_out_p=2 exercises the credit limit.
module tb_lsu_queued;
    localparam int QD = 4;
    localparam int MO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v = 1'b0, ld = 1'b0, st = 1'b0, amo = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] rs1 = '0, rs2 = '0, off = '0;
    logic [4:0]  rd = '0;
    logic [5:0]  tgx = 6'd5;
    logic [4:0]  tgy = 5'd3;
    logic        fence = 1'b0, ready = 1'b0, resp = 1'b0;

    logic        stall_a, dmem_v_a, dmem_w_a, remote_v_a, misalign_a;
    logic [9:0]  dmem_addr_a;
    logic [31:0] dmem_data_a;
    logic [3:0]  dmem_mask_a;
    logic [78:0] remote_req_a;
    logic [4:0]  out_cnt_a;

    logic        stall_b, dmem_v_b, dmem_w_b, remote_v_b, misalign_b;
    logic [9:0]  dmem_addr_b;
    logic [31:0] dmem_data_b;
    logic [3:0]  dmem_mask_b;
    logic [78:0] remote_req_b;
    logic [1:0]  out_cnt_b;

    int checks = 0;
    int failures = 0;

    // model state
    logic [78:0] mq[$];
    int          mcnt = 0;
    bit          mdrain = 0;
    bit          e_deq, e_enq, e_drained;
    logic [78:0] e_entry;

    always #5 clk = ~clk;

    lsu_queued dut_a (
        .clk_i(clk), .reset_i(rst), .v_i(v), .ld_i(ld), .st_i(st), .amo_i(amo),
        .size_i(size), .rs1_i(rs1), .rs2_i(rs2), .offset_i(off), .rd_i(rd),
        .tg_x_cord_i(tgx), .tg_y_cord_i(tgy), .fence_i(fence),
        .stall_o(stall_a), .dmem_v_o(dmem_v_a), .dmem_w_o(dmem_w_a),
        .dmem_addr_o(dmem_addr_a), .dmem_data_o(dmem_data_a), .dmem_mask_o(dmem_mask_a),
        .remote_v_o(remote_v_a), .remote_ready_i(ready), .remote_req_o(remote_req_a),
        .resp_v_i(resp), .out_cnt_o(out_cnt_a), .misalign_o(misalign_a)
    );

    lsu_queued #(.max_out_p(2)) dut_b (
        .clk_i(clk), .reset_i(rst), .v_i(v), .ld_i(ld), .st_i(st), .amo_i(amo),
        .size_i(size), .rs1_i(rs1), .rs2_i(rs2), .offset_i(off), .rd_i(rd),
        .tg_x_cord_i(tgx), .tg_y_cord_i(tgy), .fence_i(fence),
        .stall_o(stall_b), .dmem_v_o(dmem_v_b), .dmem_w_o(dmem_w_b),
        .dmem_addr_o(dmem_addr_b), .dmem_data_o(dmem_data_b), .dmem_mask_o(dmem_mask_b),
        .remote_v_o(remote_v_b), .remote_ready_i(ready), .remote_req_o(remote_req_b),
        .resp_v_i(resp), .out_cnt_o(out_cnt_b), .misalign_o(misalign_b)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // cls: 0=load 1=store 2=amo
    task automatic set_op(input bit vv, input int cls, input int sz,
                          input logic [31:0] b, input logic [31:0] o, input logic [31:0] d);
        v    = vv;
        ld   = (cls == 0);
        st   = (cls == 1);
        amo  = (cls == 2);
        size = 2'(sz);
        rs1  = b;
        off  = o;
        rs2  = d;
        rd   = 5'($urandom_range(0, 31));
    endtask

    // Evaluate this cycle's expected outputs from the model and compare.
    task automatic eval_cycle();
        logic [31:0] a;
        logic [31:0] wa;
        logic [31:0] ed;
        logic [3:0]  em;
        bit mis, loc, rem, busy, e_stall, e_acc;
        int occ;
        #1;
        a   = rs1 + off;
        mis = (size == 2'd1 && a[0]) || (size >= 2'd2 && a[1:0] != 2'b00);
        loc = !amo && ((a < 32'd4096) ||
              (a[31:29] == 3'b001 && a[21:16] == tgx && a[26:22] == tgy && a[15:0] < 16'd4096));
        rem = !mis && !loc;
        occ = mq.size();
        e_deq     = !rst && occ > 0 && ready;
        e_drained = (occ == 0) && (mcnt == 0 || (mcnt == 1 && resp));
        busy      = mdrain && !e_drained;
        e_stall   = !rst && v && (busy || (rem && ((occ == QD && !e_deq) || (mcnt + occ >= MO))));
        e_acc     = !rst && v && !e_stall;
        e_enq     = e_acc && rem;
        case (size)
            2'd0:    begin ed = {24'd0, rs2[7:0]} * 32'h0101_0101; em = 4'b0001 << a[1:0]; end
            2'd1:    begin ed = {16'd0, rs2[15:0]} * 32'h0001_0001; em = a[1] ? 4'b1100 : 4'b0011; end
            default: begin ed = rs2; em = 4'b1111; end
        endcase
        e_entry = {st, amo, em, rd, size, a[1:0], ed, a};
        check_val("stall", stall_a, e_stall);
        check_val("dmem_v", dmem_v_a, e_acc && loc && !mis);
        check_val("misalign", misalign_a, e_acc && mis);
        check_val("remote_v", remote_v_a, !rst && occ > 0);
        check_val("out_cnt", out_cnt_a, mcnt);
        check_val("b_cnt_le_max", out_cnt_b <= 2'd2, 1);
        if (e_acc && loc && !mis) begin
            wa = (a < 32'd4096) ? a : {16'd0, a[15:0]};
            check_val("dmem_w", dmem_w_a, st);
            check_val("dmem_addr", dmem_addr_a, wa / 4);
            check_val("dmem_mask", dmem_mask_a, em);
            check_val("dmem_data", dmem_data_a, ed);
        end
        if (!rst && occ > 0) check_val("req_head", remote_req_a, mq[0]);
    endtask

    // Clock edge, then the model applies the same transition.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mcnt   = 0;
            mdrain = 0;
        end else begin
            if (e_deq) void'(mq.pop_front());
            if (e_enq) mq.push_back(e_entry);
            mcnt = mcnt + (e_deq ? 1 : 0) - ((resp && mcnt > 0) ? 1 : 0);
            if (!mdrain) mdrain = fence;
            else if (e_drained) mdrain = 0;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin eval_cycle(); advance(); end
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        // reset: outputs held low even with an op presented
        set_op(1, 1, 2, 32'h100, 32'h4, 32'h1234_5678);
        rst = 1'b1;
        eval_cycle();
        check_val("rst_dmem_v", dmem_v_a, 0);
        check_val("rst_stall", stall_a, 0);
        advance();
        eval_cycle();
        check_val("rst_out_cnt", out_cnt_a, 0);
        check_val("rst_remote_v", remote_v_a, 0);
        advance();
        rst = 1'b0;

        // local word store, zero latency
        set_op(1, 1, 2, 32'h100, 32'h4, 32'hDEAD_BEEF);
        eval_cycle();
        check_val("sw_dmem_v", dmem_v_a, 1);
        check_val("sw_dmem_w", dmem_w_a, 1);
        check_val("sw_addr", dmem_addr_a, 10'h41);
        check_val("sw_mask", dmem_mask_a, 4'b1111);
        advance();

        // remote byte store, visible one cycle later
        ready = 1'b0;
        set_op(1, 1, 0, 32'h8000_0000, 32'h3, 32'h0000_00AB);
        eval_cycle();
        check_val("sb_no_bypass", remote_v_a, 0);
        advance();
        v = 1'b0;
        eval_cycle();
        check_val("sb_remote_v", remote_v_a, 1);
        check_val("sb_data", remote_req_a[63:32], 32'hABAB_ABAB);
        check_val("sb_mask", remote_req_a[76:73], 4'b1000);
        check_val("sb_write", remote_req_a[78], 1);
        advance();
        ready = 1'b1;
        eval_cycle(); advance();
        ready = 1'b0;
        resp = 1'b1;
        eval_cycle(); advance();
        resp = 1'b0;

        // FIFO full backpressure, then accept during dequeue cycle
        for (int i = 0; i < 5; i++) begin
            set_op(1, 1, 2, 32'h8000_0010 + 32'(i * 4), 32'h0, 32'(i));
            eval_cycle();
            check_val("fifo_fill_stall", stall_a, i == 4);
            advance();
        end
        ready = 1'b1;
        eval_cycle();
        check_val("full_deq_accept", stall_a, 0);
        advance();
        v = 1'b0;
        for (int i = 0; i < 6; i++) begin eval_cycle(); advance(); end
        ready = 1'b0;
        resp = 1'b1;
        for (int i = 0; i < 6; i++) begin eval_cycle(); advance(); end
        resp = 1'b0;
        eval_cycle();
        check_val("drained_cnt", out_cnt_a, 0);
        advance();

        // misaligned word load
        set_op(1, 0, 2, 32'h100, 32'h2, 32'h0);
        eval_cycle();
        check_val("mis_pulse", misalign_a, 1);
        check_val("mis_no_dmem", dmem_v_a, 0);
        check_val("mis_no_stall", stall_a, 0);
        advance();
        v = 1'b0;
        eval_cycle();
        check_val("mis_no_enq", remote_v_a, 0);
        check_val("mis_pulse_end", misalign_a, 0);
        advance();

        // fence with one outstanding
        ready = 1'b1;
        set_op(1, 0, 2, 32'h9000_0000, 32'h0, 32'h0);
        eval_cycle(); advance();
        v = 1'b0;
        eval_cycle(); advance();
        fence = 1'b1;
        eval_cycle(); advance();
        fence = 1'b0;
        set_op(1, 0, 2, 32'h200, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            eval_cycle();
            check_val("fence_stall", stall_a, 1);
            advance();
        end
        resp = 1'b1;
        eval_cycle();
        check_val("fence_release", stall_a, 0);
        advance();
        resp = 1'b0;

        // reset in the middle of a drain
        set_op(1, 0, 2, 32'h9000_0000, 32'h0, 32'h0);
        eval_cycle(); advance();
        v = 1'b0;
        eval_cycle(); advance();
        fence = 1'b1;
        eval_cycle(); advance();
        fence = 1'b0;
        set_op(1, 0, 2, 32'h200, 32'h0, 32'h0);
        eval_cycle();
        check_val("drain_stall", stall_a, 1);
        advance();
        do_reset(1);
        eval_cycle();
        check_val("post_rst_cnt", out_cnt_a, 0);
        check_val("post_rst_stall", stall_a, 0);
        advance();

        // credit limit on the max_out_p=2 instance
        v = 1'b0;
        do_reset(2);
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_op(1, 0, 2, 32'hA000_0000 + 32'(i * 4), 32'h0, 32'h0);
            eval_cycle();
            check_val("b_issue_stall", stall_b, 0);
            advance();
        end
        set_op(1, 0, 2, 32'hA000_0100, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            eval_cycle();
            check_val("b_credit_stall", stall_b, 1);
            advance();
        end
        resp = 1'b1;
        eval_cycle();
        check_val("b_resp_cycle_stall", stall_b, 1);
        advance();
        resp = 1'b0;
        eval_cycle();
        check_val("b_third_accept", stall_b, 0);
        check_val("b_cnt", out_cnt_b, 2'd1);
        advance();
        v = 1'b0;
        resp = 1'b1;
        for (int i = 0; i < 4; i++) begin eval_cycle(); advance(); end
        resp = 1'b0;

        // randomized traffic
        do_reset(1);
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] b;
            int sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: b = 32'($urandom_range(0, 4200));
                1: b = {3'b001, 2'b00,
                        ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd3,
                        ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd5,
                        16'($urandom_range(0, 16'h1400))};
                default: b = $urandom | 32'h4000_0000;
            endcase
            set_op($urandom_range(0, 3) != 0, $urandom_range(0, 2), $urandom_range(0, 2),
                   b, 32'($urandom_range(0, 7)), $urandom);
            ready = ($urandom_range(0, 1) == 1);
            resp  = ($urandom_range(0, 9) < 3);
            fence = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            eval_cycle();
            advance();
        end
        rst = 1'b0;
        v = 1'b0;
        fence = 1'b0;
        resp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_queued.md
LSU_QUEUED -- requirements
Module: lsu_queued

Interface
REQ-001 SHALL have param data_width_p, default 32, data/address width (multiple of 8).
REQ-002 SHALL have param dmem_size_p, default 1024, local DMEM depth in words.
REQ-003 SHALL have param queue_depth_p, default 4, remote request FIFO depth (>=2).
REQ-004 SHALL have param max_out_p, default 16, max outstanding remote requests.
REQ-005 SHALL have ports (name  direction  width  meaning):
  clk_i  in  1  sole clock
  reset_i  in  1  synchronous active-high reset
  v_i  in  1  EXE presents a memory op this cycle
  ld_i / st_i / amo_i  in  1 each  op class (one-hot when v_i)
  size_i  in  2  0=byte 1=half 2=word
  rs1_i / rs2_i / offset_i  in  data_width_p  base, store data, immediate
  rd_i  in  5  destination register
  tg_x_cord_i / tg_y_cord_i  in  6 / 5  own tile-group coordinates
  fence_i  in  1  drain request
  stall_o  out  1  EXE must hold op this cycle
  dmem_v_o / dmem_w_o  out  1  local DMEM access / write
  dmem_addr_o  out  clog2(dmem_size_p)  word address
  dmem_data_o / dmem_mask_o  out  data_width_p / data_width_p/8  store data/byte mask
  remote_v_o / remote_ready_i  out / in  1  network TX handshake
  remote_req_o  out  packed  {write, amo, mask, rd, size, part_sel, data, addr}
  resp_v_i  in  1  one remote response retired this cycle
  out_cnt_o  out  clog2(max_out_p+1)  outstanding count
  misalign_o  out  1  pulse: misaligned op dropped

Function
REQ-006 SHALL compute addr = rs1_i + offset_i modulo 2^data_width_p, combinationally.
REQ-007 SHALL class addr local if addr < 4*dmem_size_p, or tile-group format (addr[31:29]==3'b001, x/y fields equal tg_*) with 16-bit offset field < 4*dmem_size_p; AMO is never local.
REQ-008 SHALL replicate store data and form mask: byte -> one-hot on addr[1:0]; half -> 2'b11 at addr[1]; word -> all ones.
REQ-009 SHALL flag misaligned when half with addr[0]=1 or word with addr[1:0]!=0; such op SHALL pulse misalign_o one cycle, issue nothing, not stall.
REQ-010 Local op with v_i & ~stall_o SHALL assert dmem_v_o same cycle (zero latency), dmem_w_o=st_i, dmem_addr_o=addr word index.
REQ-011 Remote op with v_i & ~stall_o SHALL enqueue one FIFO entry; FIFO head drives remote_req_o; remote_v_o = FIFO non-empty.
REQ-012 Entry SHALL dequeue on remote_v_o & remote_ready_i; remote_req_o SHALL hold stable while remote_v_o & ~remote_ready_i.
REQ-013 out_cnt SHALL increment on dequeue, decrement on resp_v_i, unchanged when both; resp_v_i at out_cnt=0 SHALL be ignored (no underflow).
REQ-014 stall_o SHALL assert for remote op when FIFO full and no same-cycle dequeue, or when out_cnt + FIFO occupancy >= max_out_p.
REQ-015 Full FIFO with simultaneous dequeue SHALL accept new entry (no bubble); empty FIFO SHALL not bypass (min remote latency 1 cycle).
REQ-016 FIFO pointers SHALL wrap modulo queue_depth_p (non-power-of-2 depths supported).
REQ-017 Fence FSM states IDLE, DRAIN: IDLE->DRAIN on fence_i; DRAIN asserts stall_o for all ops; DRAIN->IDLE when FIFO empty and out_cnt=0 (same cycle, stall_o deasserts that cycle); fence_i with already-empty state SHALL not stall.
REQ-018 Local ops SHALL never wait on FIFO/credits, except under DRAIN.

Reset
REQ-019 On reset_i at any clock edge: FIFO empty, out_cnt_o=0, FSM=IDLE; in-flight entries SHALL be discarded.
REQ-020 While reset_i high: remote_v_o=0, dmem_v_o=0, misalign_o=0, stall_o=0.

Verification
REQ-021 sw rs1=0x100 offset=4 -> dmem_v_o=1, dmem_w_o=1, dmem_addr_o=0x41, mask 4'b1111, same cycle.
REQ-022 sb to 0x8000_0003, rs2=0xAB -> one FIFO entry, data 0xABABABAB, mask 4'b1000, remote_v_o next cycle.
REQ-023 remote_ready_i=0, 5 remote stores (depth 4) -> 5th stalls; raise ready with 5th held -> accepted in dequeue cycle.
REQ-024 max_out_p=2, issue 2 loads, no responses -> 3rd stalls; one resp_v_i -> 3rd accepted next cycle; out_cnt_o never exceeds 2.
REQ-025 lw to 0x102 -> misalign_o pulse, no dmem_v_o, no enqueue.
REQ-026 fence_i with 1 outstanding -> stall_o until resp_v_i, deasserts that cycle; reset mid-DRAIN -> IDLE, out_cnt_o=0.
